// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two prioritised
// write ports, optional write-to-read bypass, optional hardwired-zero r0,
// per-register busy scoreboard and an unbypassed debug read port.
module regfile_mp #(
    parameter  int unsigned WIDTH    = 32,
    parameter  int unsigned DEPTH    = 32,
    parameter  int unsigned NRD      = 2,
    parameter  int unsigned BYPASS   = 1,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rd,
    output logic [NRD-1:0]       rbusy,
    input  logic                 we0,
    input  logic [AW-1:0]        wa0,
    input  logic [WIDTH-1:0]     wd0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa1,
    input  logic [WIDTH-1:0]     wd1,
    input  logic                 bset,
    input  logic [AW-1:0]        ba,
    input  logic [AW-1:0]        dbg_a,
    output logic [WIDTH-1:0]     dbg_d
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    logic wr0_ok;
    logic wr1_ok;

    // Write qualification: register 0 swallows writes when hardwired to zero
    always_comb begin
        wr0_ok = we0 && !((ZERO_REG != 0) && (wa0 == '0));
        wr1_ok = we1 && !((ZERO_REG != 0) && (wa1 == '0));
    end

    // Next-state storage; port 1 is applied last so it wins an address clash
    always_comb begin
        mem_d = mem_q;
        if (wr0_ok) begin
            mem_d[wa0] = wd0;
        end
        if (wr1_ok) begin
            mem_d[wa1] = wd1;
        end
    end

    // Next-state scoreboard: a write retires the producer, a new issue (bset)
    // overrides a retiring write on the same register
    always_comb begin
        busy_d = busy_q;
        if (we0) begin
            busy_d[wa0] = 1'b0;
        end
        if (we1) begin
            busy_d[wa1] = 1'b0;
        end
        if (bset) begin
            busy_d[ba] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    // Read ports: stored value with bypass and zero-register overrides,
    // forced to zero while reset is asserted
    always_comb begin
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        logic             b;
        rd    = '0;
        rbusy = '0;
        a     = '0;
        d     = '0;
        b     = 1'b0;
        for (int unsigned i = 0; i < NRD; i++) begin
            a = ra[i*AW +: AW];
            d = mem_q[a];
            b = busy_q[a];
            if ((BYPASS != 0) && we0 && (wa0 == a)) begin
                d = wd0;
                b = 1'b0;
            end
            if ((BYPASS != 0) && we1 && (wa1 == a)) begin
                d = wd1;
                b = 1'b0;
            end
            if ((ZERO_REG != 0) && (a == '0)) begin
                d = '0;
                b = 1'b0;
            end
            if (!rstn) begin
                d = '0;
                b = 1'b0;
            end
            rd[i*WIDTH +: WIDTH] = d;
            rbusy[i]             = b;
        end
    end

    // Debug port: stored value only, zero-register aware
    always_comb begin
        dbg_d = mem_q[dbg_a];
        if (((ZERO_REG != 0) && (dbg_a == '0)) || !rstn) begin
            dbg_d = '0;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: dut_a (NRD=4, bypass, zero reg) and
// dut_b (NRD=2, no bypass, r0 writable) share write/issue stimulus.
module tb_regfile_mp;

    localparam logic [31:0] Z0  = 32'h0000_0000;
    localparam logic [31:0] R3  = 32'h1234_5678;
    localparam logic [31:0] R12 = 32'h8765_4321;
    localparam logic [31:0] D3  = 32'h1111_1111;
    localparam logic [31:0] R7  = 32'h0000_0777;
    localparam logic [31:0] F   = 32'hffff_ffff;
    localparam logic [31:0] X5  = 32'h0000_0055;
    localparam logic [31:0] Y5  = 32'h0000_5a5a;
    localparam logic [31:0] W0  = 32'h0000_1234;

    logic         clk;
    logic         rstn;
    logic [19:0]  ra_a;
    logic [9:0]   ra_b;
    logic [127:0] rd_a;
    logic [63:0]  rd_b;
    logic [3:0]   rbusy_a;
    logic [1:0]   rbusy_b;
    logic         we0, we1, bset;
    logic [4:0]   wa0, wa1, ba, dbg_a;
    logic [31:0]  wd0, wd1;
    logic [31:0]  dbg_d_a, dbg_d_b;

    int tests;
    int fails;

    typedef struct {
        logic            we0;
        logic [4:0]      wa0;
        logic [31:0]     wd0;
        logic            we1;
        logic [4:0]      wa1;
        logic [31:0]     wd1;
        logic            bset;
        logic [4:0]      ba;
        logic [0:3][4:0] ra;
        logic [4:0]      dbg_a;
        logic [0:3][31:0] a_rd;
        logic [0:3]      a_busy;
        logic [31:0]     a_dbg;
        logic [0:1][31:0] b_rd;
        logic [0:1]      b_busy;
        logic [31:0]     b_dbg;
    } vec_t;

    vec_t vecs[14];

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(4), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rstn(rstn), .ra(ra_a), .rd(rd_a), .rbusy(rbusy_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .bset(bset), .ba(ba), .dbg_a(dbg_a), .dbg_d(dbg_d_a)
    );

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rstn(rstn), .ra(ra_b), .rd(rd_b), .rbusy(rbusy_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .bset(bset), .ba(ba), .dbg_a(dbg_a), .dbg_d(dbg_d_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_ra(input logic [0:3][4:0] r);
        for (int i = 0; i < 4; i++) begin
            ra_a[i*5 +: 5] = r[i];
        end
        ra_b = {r[1], r[0]};
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        bset = 1'b0; ba = '0;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        vecs[0]  = '{1'b1, 5'h12, R12, 1'b0, 5'h00, Z0, 1'b0, 5'h00, {5'h12, 5'h12, 5'h03, 5'h07}, 5'h12,
                     {R12, R12, R3, Z0}, 4'b0000, Z0, {Z0, Z0}, 2'b00, Z0};
        vecs[1]  = '{1'b0, 5'h00, Z0, 1'b0, 5'h00, Z0, 1'b0, 5'h00, {5'h12, 5'h03, 5'h12, 5'h07}, 5'h12,
                     {R12, R3, R12, Z0}, 4'b0000, R12, {R12, R3}, 2'b00, R12};
        vecs[2]  = '{1'b1, 5'h03, 32'habcdef01, 1'b1, 5'h03, D3, 1'b0, 5'h00, {5'h03, 5'h07, 5'h03, 5'h12}, 5'h03,
                     {D3, Z0, D3, R12}, 4'b0000, R3, {R3, Z0}, 2'b00, R3};
        vecs[3]  = '{1'b0, 5'h00, Z0, 1'b0, 5'h00, Z0, 1'b0, 5'h00, {5'h03, 5'h12, 5'h03, 5'h07}, 5'h03,
                     {D3, R12, D3, Z0}, 4'b0000, D3, {D3, R12}, 2'b00, D3};
        vecs[4]  = '{1'b0, 5'h00, Z0, 1'b1, 5'h07, R7, 1'b0, 5'h00, {5'h07, 5'h07, 5'h03, 5'h12}, 5'h07,
                     {R7, R7, D3, R12}, 4'b0000, Z0, {Z0, Z0}, 2'b00, Z0};
        vecs[5]  = '{1'b1, 5'h00, F, 1'b1, 5'h00, F, 1'b1, 5'h00, {5'h00, 5'h00, 5'h07, 5'h00}, 5'h00,
                     {Z0, Z0, R7, Z0}, 4'b0000, Z0, {Z0, Z0}, 2'b00, Z0};
        vecs[6]  = '{1'b0, 5'h00, Z0, 1'b0, 5'h00, Z0, 1'b0, 5'h00, {5'h00, 5'h05, 5'h00, 5'h07}, 5'h00,
                     {Z0, Z0, Z0, R7}, 4'b0000, Z0, {F, Z0}, 2'b10, F};
        vecs[7]  = '{1'b0, 5'h00, Z0, 1'b0, 5'h00, Z0, 1'b1, 5'h05, {5'h05, 5'h00, 5'h05, 5'h07}, 5'h05,
                     {Z0, Z0, Z0, R7}, 4'b0000, Z0, {Z0, F}, 2'b01, Z0};
        vecs[8]  = '{1'b0, 5'h00, Z0, 1'b0, 5'h00, Z0, 1'b0, 5'h00, {5'h05, 5'h00, 5'h05, 5'h07}, 5'h05,
                     {Z0, Z0, Z0, R7}, 4'b1010, Z0, {Z0, F}, 2'b11, Z0};
        vecs[9]  = '{1'b1, 5'h05, X5, 1'b0, 5'h00, Z0, 1'b0, 5'h00, {5'h05, 5'h00, 5'h05, 5'h07}, 5'h05,
                     {X5, Z0, X5, R7}, 4'b0000, Z0, {Z0, F}, 2'b11, Z0};
        vecs[10] = '{1'b0, 5'h00, Z0, 1'b1, 5'h05, Y5, 1'b1, 5'h05, {5'h05, 5'h00, 5'h05, 5'h07}, 5'h05,
                     {Y5, Z0, Y5, R7}, 4'b0000, X5, {X5, F}, 2'b01, X5};
        vecs[11] = '{1'b0, 5'h00, Z0, 1'b0, 5'h00, Z0, 1'b0, 5'h00, {5'h05, 5'h00, 5'h05, 5'h07}, 5'h05,
                     {Y5, Z0, Y5, R7}, 4'b1010, Y5, {Y5, F}, 2'b11, Y5};
        vecs[12] = '{1'b1, 5'h00, W0, 1'b0, 5'h00, Z0, 1'b0, 5'h00, {5'h05, 5'h00, 5'h05, 5'h07}, 5'h05,
                     {Y5, Z0, Y5, R7}, 4'b1010, Y5, {Y5, F}, 2'b11, Y5};
        vecs[13] = '{1'b0, 5'h00, Z0, 1'b0, 5'h00, Z0, 1'b0, 5'h00, {5'h05, 5'h00, 5'h05, 5'h07}, 5'h05,
                     {Y5, Z0, Y5, R7}, 4'b1010, Y5, {Y5, W0}, 2'b10, Y5};

        // Reset held while a write is presented: nothing may be stored or shown
        rstn = 1'b0;
        idle_inputs();
        we0 = 1'b1; wa0 = 5'd3; wd0 = R3;
        set_ra({5'h03, 5'h03, 5'h03, 5'h03});
        dbg_a = 5'd3;
        @(negedge clk);
        #1;
        check("rst a_rd0", rd_a[31:0], Z0);
        check("rst a_busy", {28'd0, rbusy_a}, Z0);
        check("rst a_dbg", dbg_d_a, Z0);
        check("rst b_rd0", rd_b[31:0], Z0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        check("post-rst a_rd0", rd_a[31:0], R3);
        check("post-rst b_rd0", rd_b[31:0], R3);
        check("post-rst a_dbg", dbg_d_a, R3);

        // Table-driven vectors: comparisons made before the edge that applies the inputs
        for (int v = 0; v < 14; v++) begin
            @(negedge clk);
            we0 = vecs[v].we0; wa0 = vecs[v].wa0; wd0 = vecs[v].wd0;
            we1 = vecs[v].we1; wa1 = vecs[v].wa1; wd1 = vecs[v].wd1;
            bset = vecs[v].bset; ba = vecs[v].ba;
            set_ra(vecs[v].ra);
            dbg_a = vecs[v].dbg_a;
            #1;
            for (int p = 0; p < 4; p++) begin
                check($sformatf("v%0d a_rd%0d", v, p), rd_a[p*32 +: 32], vecs[v].a_rd[p]);
                check($sformatf("v%0d a_busy%0d", v, p), {31'd0, rbusy_a[p]}, {31'd0, vecs[v].a_busy[p]});
            end
            check($sformatf("v%0d a_dbg", v), dbg_d_a, vecs[v].a_dbg);
            for (int p = 0; p < 2; p++) begin
                check($sformatf("v%0d b_rd%0d", v, p), rd_b[p*32 +: 32], vecs[v].b_rd[p]);
                check($sformatf("v%0d b_busy%0d", v, p), {31'd0, rbusy_b[p]}, {31'd0, vecs[v].b_busy[p]});
            end
            check($sformatf("v%0d b_dbg", v), dbg_d_b, vecs[v].b_dbg);
        end

        // Mid-operation reset: clears at once, and the write/issue on that edge is lost
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h0000_dead;
        bset = 1'b1; ba = 5'd3;
        set_ra({5'h05, 5'h03, 5'h05, 5'h07});
        dbg_a = 5'd5;
        rstn = 1'b0;
        #1;
        check("mid-rst a_rd0", rd_a[31:0], Z0);
        check("mid-rst a_rd3", rd_a[127:96], Z0);
        check("mid-rst a_busy", {28'd0, rbusy_a}, Z0);
        check("mid-rst a_dbg", dbg_d_a, Z0);
        check("mid-rst b_rd1", rd_b[63:32], Z0);
        @(negedge clk);
        rstn = 1'b1;
        idle_inputs();
        #1;
        check("after-rst a_rd0", rd_a[31:0], Z0);
        check("after-rst a_rd3", rd_a[127:96], Z0);
        check("after-rst a_busy", {28'd0, rbusy_a}, Z0);
        check("after-rst b_rd0", rd_b[31:0], Z0);
        check("after-rst b_busy", {30'd0, rbusy_b}, Z0);
        check("after-rst b_dbg", dbg_d_b, Z0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
